// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-stage interlock controller for the R2000 pipeline.
// It tracks the destination tags of the instructions in EX, MEM and WB and
// stalls ID on read-after-write hazards against the rs/rt operands.
// Optional feature macro: HAZARD_FWD_EN
//   defined   -> forwarding mode: only load-use stalls, and registered
//                forwarding selects are driven for the EX operand muxes.
//   undefined -> full interlock: any EX/MEM producer stalls, selects tied 00.
module hazard_scoreboard #(
    parameter  int NREG  = 32,
    parameter  int CNT_W = 16,
    localparam int RW    = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [RW-1:0]    id_rs,
    input  logic [RW-1:0]    id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [RW-1:0]    id_dest,
    input  logic             id_wr,
    input  logic             id_load,
    input  logic             id_flush,
    input  logic             pipe_freeze,
    output logic             id_stall,
    output logic             ex_bubble,
    output logic [1:0]       fwd_rs_sel,
    output logic [1:0]       fwd_rt_sel,
    output logic [CNT_W-1:0] stall_count
);

    // One in-flight producer: valid, destination register, and load flag.
    typedef struct packed {
        logic          v;
        logic [RW-1:0] dest;
        logic          load;
    } tag_t;

    localparam logic [1:0] SEL_RF  = 2'b00;  // register file
    localparam logic [1:0] SEL_EXM = 2'b01;  // EX/MEM result
    localparam logic [1:0] SEL_MWB = 2'b10;  // MEM/WB result

    tag_t ex_tag, mem_tag, wb_tag;
    tag_t ex_next;
    logic rs_ex, rs_mem, rt_ex, rt_mem;
    logic hazard;
    logic issue;

    // A source matches a producer only if it is really read, the producer
    // really writes, and the register is not r0.
    function automatic logic src_match(input logic use_bit, input logic [RW-1:0] src,
                                       input tag_t tag);
        return use_bit & tag.v & (src == tag.dest) & (src != '0);
    endfunction

    // Operand-versus-tag comparisons for the instruction sitting in ID.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rs_ex  = 1'b0;
        rs_mem = 1'b0;
        rt_ex  = 1'b0;
        rt_mem = 1'b0;
        rs_ex  = src_match(id_use_rs, id_rs, ex_tag);
        rs_mem = src_match(id_use_rs, id_rs, mem_tag);
        rt_ex  = src_match(id_use_rt, id_rt, ex_tag);
        rt_mem = src_match(id_use_rt, id_rt, mem_tag);
    end

`ifdef HAZARD_FWD_EN
    // Forwarding covers everything except a load still in EX (load-use).
    assign hazard = (rs_ex | rt_ex) & ex_tag.load;
`else
    // No bypass paths: any producer still in EX or MEM must drain first.
    // A WB producer is safe because the register file writes before it reads.
    assign hazard = rs_ex | rs_mem | rt_ex | rt_mem;
`endif

    assign id_stall = id_valid & hazard & ~id_flush;
    assign issue    = id_valid & ~id_stall & ~id_flush;

    // Tag entering EX; a write to r0 is never a hazard source, so it is dropped.
    always_comb begin
        ex_next      = '0;
        ex_next.v    = issue & id_wr & (id_dest != '0);
        ex_next.dest = id_dest;
        ex_next.load = issue & id_load;
    end

    // Tag pipeline EX -> MEM -> WB; holds while the pipe is frozen.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and the shift happens in one step.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_tag  <= '0;
            mem_tag <= '0;
            wb_tag  <= '0;
        end else if (!pipe_freeze) begin
            wb_tag  <= mem_tag;
            mem_tag <= ex_tag;
            ex_tag  <= ex_next;
        end
    end

    // EX slot is a bubble whenever nothing issued from ID.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_bubble <= 1'b1;
        end else if (!pipe_freeze) begin
            ex_bubble <= ~issue;
        end
    end

    // Saturating count of cycles in which ID was held.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (id_stall && !pipe_freeze && !(&stall_count)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

`ifdef HAZARD_FWD_EN
    // Selects are resolved at issue and registered for the EX cycle; the EX
    // tag wins because it is the youngest producer of the register.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_rs_sel <= SEL_RF;
            fwd_rt_sel <= SEL_RF;
        end else if (!pipe_freeze) begin
            if (issue) begin
                fwd_rs_sel <= rs_ex ? SEL_EXM : (rs_mem ? SEL_MWB : SEL_RF);
                fwd_rt_sel <= rt_ex ? SEL_EXM : (rt_mem ? SEL_MWB : SEL_RF);
            end else begin
                fwd_rs_sel <= SEL_RF;
                fwd_rt_sel <= SEL_RF;
            end
        end
    end
`else
    assign fwd_rs_sel = SEL_RF;
    assign fwd_rt_sel = SEL_RF;
`endif

    // The WB tag is kept for pipeline bookkeeping only, and the load flag
    // matters only in EX under forwarding; these bits are sunk here.
    logic unused_tag_bits;
    assign unused_tag_bits = ^{ex_tag.load, mem_tag.load, wb_tag, SEL_EXM, SEL_MWB};

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: table-driven check of hazard_scoreboard, with a
// scoreboard queue holding the registered outputs expected after each edge.
// Expectations follow the build mode selected by HAZARD_FWD_EN.
module tb_hazard_scoreboard;

    localparam int TB_CNT_W = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                id_valid;
    logic [4:0]          id_rs, id_rt, id_dest;
    logic                id_use_rs, id_use_rt, id_wr, id_load, id_flush, pipe_freeze;
    logic                id_stall, ex_bubble;
    logic [1:0]          fwd_rs_sel, fwd_rt_sel;
    logic [TB_CNT_W-1:0] stall_count;

    hazard_scoreboard #(.NREG(32), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest), .id_wr(id_wr),
        .id_load(id_load), .id_flush(id_flush), .pipe_freeze(pipe_freeze),
        .id_stall(id_stall), .ex_bubble(ex_bubble), .fwd_rs_sel(fwd_rs_sel),
        .fwd_rt_sel(fwd_rt_sel), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic                bubble;
        logic [1:0]          rs_sel;
        logic [1:0]          rt_sel;
        logic [TB_CNT_W-1:0] cnt;
    } exp_t;

    typedef struct {
        logic       valid;
        logic [4:0] rs, rt;
        logic       use_rs, use_rt;
        logic [4:0] dest;
        logic       wr, load, flush, freeze, rst;
        logic       stall;   // combinational, same cycle
        exp_t       e;       // registered, after the edge
    } vec_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Column order: valid rs rt use_rs use_rt dest wr load flush freeze rst |
    //               exp_stall exp_bubble exp_rs_sel exp_rt_sel exp_count
    function automatic void vec(input int valid, input int rs, input int rt, input int urs,
                                input int urt, input int dest, input int wr, input int ld,
                                input int fl, input int fz, input int rs_t, input int st,
                                input int bub, input int rss, input int rts, input int cnt);
        vec_t t;
        t.valid = 1'(valid);   t.rs = 5'(rs);       t.rt = 5'(rt);
        t.use_rs = 1'(urs);    t.use_rt = 1'(urt);  t.dest = 5'(dest);
        t.wr = 1'(wr);         t.load = 1'(ld);     t.flush = 1'(fl);
        t.freeze = 1'(fz);     t.rst = 1'(rs_t);    t.stall = 1'(st);
        t.e.bubble = 1'(bub);  t.e.rs_sel = 2'(rss); t.e.rt_sel = 2'(rts);
        t.e.cnt = TB_CNT_W'(cnt);
        tbl.push_back(t);
    endfunction

    // Drive one cycle, check id_stall combinationally, then compare the
    // registered outputs against the scoreboard entry after the edge.
    task automatic apply(input vec_t t, input string tag);
        exp_t got;
        id_valid = t.valid;  id_rs = t.rs;       id_rt = t.rt;
        id_use_rs = t.use_rs; id_use_rt = t.use_rt; id_dest = t.dest;
        id_wr = t.wr;        id_load = t.load;   id_flush = t.flush;
        pipe_freeze = t.freeze; rst = t.rst;
        #1;
        check({tag, " id_stall"}, 32'(id_stall), 32'(t.stall));
        sb.push_back(t.e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check({tag, " ex_bubble"}, 32'(ex_bubble), 32'(got.bubble));
        check({tag, " fwd_rs_sel"}, 32'(fwd_rs_sel), 32'(got.rs_sel));
        check({tag, " fwd_rt_sel"}, 32'(fwd_rt_sel), 32'(got.rt_sel));
        check({tag, " stall_count"}, 32'(stall_count), 32'(got.cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t t;
        int   cnt;
        int   nst;
        logic fwd;
`ifdef HAZARD_FWD_EN
        fwd = 1'b1;
`else
        fwd = 1'b0;
`endif
        // Second reset cycle: ID holds a reader of r5, nothing in flight.
        vec(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 1,   0, 1, 0, 0, 0);
`ifdef HAZARD_FWD_EN
        vec(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0);  // add r3
        vec(1, 3, 0, 1, 0, 5, 1, 0, 0, 0, 0,   0, 0, 1, 0, 0);  // sub rs=r3 -> 01
        vec(1, 0, 3, 0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 2, 0);  // rt=r3 in MEM -> 10
        vec(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0);  // add r6
        vec(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0);  // add r6 again
        vec(1, 6, 0, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0);  // EX beats MEM -> 01
        vec(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0);  // lw r4
        vec(1, 0, 4, 0, 1, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 1);  // load-use stall
        vec(1, 0, 4, 0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 2, 1);  // issues, rt -> 10
        vec(1, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0,   0, 0, 0, 0, 1);  // lw r8
        vec(1, 8, 0, 1, 0, 0, 0, 0, 0, 1, 0,   1, 0, 0, 0, 1);  // frozen stall
        vec(1, 8, 0, 1, 0, 0, 0, 0, 0, 1, 0,   1, 0, 0, 0, 1);
        vec(1, 8, 0, 1, 0, 0, 0, 0, 0, 1, 0,   1, 0, 0, 0, 1);
        vec(1, 8, 0, 1, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 2);  // freeze drops
        vec(1, 8, 0, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 2, 0, 2);  // resolves
        vec(1, 0, 0, 0, 0, 11, 1, 1, 0, 0, 0,  0, 0, 0, 0, 2);  // lw r11
        vec(1, 11, 0, 1, 0, 0, 0, 0, 1, 0, 0,  0, 1, 0, 0, 2);  // flush beats stall
        vec(1, 11, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2, 0, 2);  // r11 now in MEM
        vec(1, 0, 0, 0, 0, 13, 1, 1, 0, 0, 0,  0, 0, 0, 0, 2);  // lw r13
        vec(1, 13, 0, 1, 0, 0, 0, 0, 0, 0, 1,  1, 1, 0, 0, 0);  // reset mid-stall
        vec(1, 13, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);  // issues cleanly
        vec(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0);  // lw r0
        vec(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);  // r0 never hazards
`else
        vec(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0);  // add r3
        vec(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 1);  // EX match
        vec(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 2);  // MEM match
        vec(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 2);  // WB: issues
        vec(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 2);  // write r0
        vec(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 2);  // read r0
        vec(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0,   0, 0, 0, 0, 2);  // add r7
        vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 2);  // independent
        vec(1, 0, 7, 0, 1, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 3);  // distance 2
        vec(1, 0, 7, 0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 3);
        vec(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0,   0, 0, 0, 0, 3);  // add r9
        vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 3);
        vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 3);
        vec(1, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 3);  // distance 3
        vec(1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0,  0, 0, 0, 0, 3);  // add r10
        vec(1, 10, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);  // use bits clear
        vec(1, 0, 0, 0, 0, 11, 1, 0, 0, 0, 0,  0, 0, 0, 0, 3);  // add r11
        vec(1, 11, 0, 1, 0, 0, 0, 0, 1, 0, 0,  0, 1, 0, 0, 3);  // flush beats stall
        vec(1, 11, 0, 1, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 4);  // r11 in MEM
        vec(1, 11, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4);
        vec(0, 11, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 4);  // ID empty
        vec(1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 0,  0, 0, 0, 0, 4);  // add r12
        vec(1, 12, 0, 1, 0, 0, 0, 0, 0, 1, 0,  1, 0, 0, 0, 4);  // frozen stall
        vec(1, 12, 0, 1, 0, 0, 0, 0, 0, 1, 0,  1, 0, 0, 0, 4);
        vec(1, 12, 0, 1, 0, 0, 0, 0, 0, 1, 0,  1, 0, 0, 0, 4);
        vec(1, 12, 0, 1, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 5);  // freeze drops
        vec(1, 12, 0, 1, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 6);
        vec(1, 12, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 6);
        vec(1, 0, 0, 0, 0, 13, 1, 0, 0, 0, 0,  0, 0, 0, 0, 6);  // add r13
        vec(1, 13, 0, 1, 0, 0, 0, 0, 0, 0, 1,  1, 1, 0, 0, 0);  // reset mid-stall
        vec(1, 13, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);  // issues cleanly
`endif
        // First reset cycle, unchecked: state is unknown before it.
        rst = 1'b1; id_valid = 1'b1; id_rs = 5'd5; id_rt = '0; id_use_rs = 1'b1;
        id_use_rt = 1'b0; id_dest = '0; id_wr = 1'b0; id_load = 1'b0;
        id_flush = 1'b0; pipe_freeze = 1'b0;
        @(posedge clk);
        #1;

        foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

        // Saturation: repeated load -> dependent-reader pairs push the
        // counter past all-ones; it must stick at all-ones.
        cnt = 0;
        nst = fwd ? 1 : 2;
        for (int p = 0; p < 17; p++) begin
            t = '{valid: 1'b1, rs: '0, rt: '0, use_rs: 1'b0, use_rt: 1'b0, dest: 5'd20,
                  wr: 1'b1, load: 1'b1, flush: 1'b0, freeze: 1'b0, rst: 1'b0, stall: 1'b0,
                  e: '{bubble: 1'b0, rs_sel: 2'b00, rt_sel: 2'b00, cnt: TB_CNT_W'(cnt)}};
            apply(t, $sformatf("sat%0d prod", p));
            t.rs = 5'd20; t.use_rs = 1'b1; t.dest = '0; t.wr = 1'b0; t.load = 1'b0;
            for (int s = 0; s < nst; s++) begin
                cnt = (cnt < (1 << TB_CNT_W) - 1) ? cnt + 1 : cnt;
                t.stall = 1'b1;
                t.e = '{bubble: 1'b1, rs_sel: 2'b00, rt_sel: 2'b00, cnt: TB_CNT_W'(cnt)};
                apply(t, $sformatf("sat%0d stall%0d", p, s));
            end
            t.stall = 1'b0;
            t.e = '{bubble: 1'b0, rs_sel: fwd ? 2'b10 : 2'b00, rt_sel: 2'b00,
                    cnt: TB_CNT_W'(cnt)};
            apply(t, $sformatf("sat%0d use", p));
        end
        check("saturated stall_count", 32'(stall_count), 32'((1 << TB_CNT_W) - 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Pipeline interlock controller for the MIPS R2000 decode stage. It tracks the destination registers of the instructions in flight in EX, MEM and WB, and detects read-after-write hazards on the rs/rt operands that ID is about to read from the register file. It stalls ID, inserts a bubble into EX, and optionally produces registered forwarding selects for the EX operand muxes. It sits beside the ID stage and drives the ID/EX pipeline-register enables.

## Interface
Parameters:
- `NREG`, 32: architectural register count; register 0 is never a hazard source.
- `CNT_W`, 16: width of the stall statistics counter.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs`, `id_rt` in 5: source register numbers of the ID instruction.
- `id_use_rs`, `id_use_rt` in 1: the instruction actually reads rs/rt.
- `id_dest` in 5: destination register of the ID instruction.
- `id_wr` in 1: the instruction writes `id_dest`.
- `id_load` in 1: the instruction is a load, so its result is available only after MEM.
- `id_flush` in 1: kill the ID instruction (taken branch/jump).
- `pipe_freeze` in 1: global freeze (memory wait); all state holds.
- `id_stall` out 1: combinational; hold PC and IF/ID, do not issue.
- `ex_bubble` out 1: registered; the current EX slot is a bubble.
- `fwd_rs_sel`, `fwd_rt_sel` out 2: registered; EX operand select. 00 = regfile, 01 = EX/MEM result, 10 = MEM/WB result.
- `stall_count` out CNT_W: registered, saturating count of stall cycles.

## Operation
- Three tag registers, `EX`, `MEM`, `WB`, each holding {v, dest, load}. A tag with `dest==0` is forced to v=0.
- Issue condition: `issue = id_valid & ~id_stall & ~id_flush`.
- Each unfrozen cycle the tags shift: WB<=MEM, MEM<=EX, EX<={issue & id_wr, id_dest, id_load}. When nothing issues, EX<=invalid and `ex_bubble`<=1.
- A source "matches" a tag when the use bit is set, the tag is valid, the numbers are equal, and the source is nonzero.
- Hazard without forwarding: a match on EX or MEM causes a stall. A WB match causes no stall, because the register file writes before it reads.
- Hazard with forwarding: only a match on EX with load=1 (load-use) causes a stall, for exactly one cycle.
- Forward selects are computed at issue and registered, so they are valid during that instruction's EX cycle:
  - match on EX tag gives 01;
  - else match on MEM tag gives 10;
  - else 00.
  - The EX tag has priority because it is the youngest producer.
- A bubble or non-issue loads 00 into both selects.
- `id_stall = id_valid & hazard & ~id_flush`. Flush wins over stall.
- `stall_count` increments when `id_stall & ~pipe_freeze`, and saturates at all-ones.
- `pipe_freeze=1`: tags, selects, `ex_bubble` and `stall_count` all hold. `id_stall` is still evaluated combinationally.

## Timing
- Reset values: all tags invalid, `ex_bubble`=1, `fwd_rs_sel`=`fwd_rt_sel`=00, `stall_count`=0. `id_stall`=0 because no tag is valid.
- Reset mid-stall: the next cycle has no hazard and ID issues.
- Hazard-to-stall latency is 0 cycles (same cycle). Selects and `ex_bubble` appear 1 cycle after issue.
- Without forwarding, a dependent instruction immediately after its producer stalls for 2 cycles. Producer-to-consumer distance of 2 gives 1 stall cycle; distance 3 or more gives none.
- With forwarding, load-use costs 1 stall cycle. ALU-to-ALU dependencies cost none.
- A stall cycle always shifts a bubble into EX (unless frozen).

## Configuration
- `HAZARD_FWD_EN` defined: forwarding mode as described. Selects are driven and only load-use stalls.
- `HAZARD_FWD_EN` undefined: full interlock mode. `fwd_rs_sel`/`fwd_rt_sel` are tied to 00 and stalls follow the no-forwarding rule.

## Test plan
- Reset: hold `rst` for 2 cycles → `stall_count`=0, selects 00, `ex_bubble`=1, `id_stall`=0 with `id_valid`=1, `id_rs`=5.
- FWD: `add r3`, then next cycle `sub` reading rs=3 → no stall; in sub's EX cycle `fwd_rs_sel`=01. A second reader one instruction later gets 10.
- FWD: `lw r4` then `add` reading rt=4 → `id_stall`=1 for 1 cycle, `ex_bubble`=1, `stall_count`=1. Add then issues with `fwd_rt_sel`=10.
- No FWD: `add r3` then reader of r3 → 2 stall cycles, `stall_count`=2. A reader of r0 after a write to r0 → no stall.
- `pipe_freeze`=1 during a load-use stall for 3 cycles → tags and `stall_count` hold, `id_stall` stays 1, and the stall resolves 1 cycle after the freeze drops.
- `id_flush`=1 while a hazard is present → `id_stall`=0, a bubble enters EX, `stall_count` is unchanged. `stall_count` forced near 2^CNT_W-1 saturates at all-ones.
